// File: rtl/sparc_fetch_sequencer.sv
// rtl/sparc_fetch_sequencer.sv - SPARC PC/nPC fetch sequencer with delayed control transfer
module sparc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic        cti_valid,
  input  logic        cond_true,
  input  logic        is_ba,
  input  logic        annul_bit,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic [31:0] PC,
  output logic [31:0] nPC,
  output logic        if_id_le,
  output logic        if_id_reset,
  output logic        fetch_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {RST, WARM, RUN} state_t;

  state_t state;
  state_t state_next;
  state_t phase;

  logic        taken;
  logic        redirect;
  logic        squash;
  logic        advance;
  logic [31:0] target_raw;
  logic [31:0] target;

  // The register sits at RST until the first edge after clr rises; that
  // released-but-not-yet-clocked interval is the WARM cycle.
  always_comb begin
    phase = state;
    if (state == RST && clr) phase = WARM;
  end

  // Branch resolution: jump outranks branch for the target, annul uses branch fields only
  always_comb begin
    taken      = cti_valid & (cond_true | is_ba);
    redirect   = taken | jump_valid;
    target_raw = jump_valid ? jump_target : branch_target;
    target     = target_raw & 32'hFFFF_FFFC;
    squash     = cti_valid & annul_bit & (~taken | is_ba);
  end

  // Phase sequencing and pipeline-register controls
  always_comb begin
    state_next  = state;
    if_id_le    = 1'b0;
    if_id_reset = 1'b1;
    fetch_valid = 1'b0;
    advance     = 1'b0;
    case (phase)
      RST:  state_next = RST;
      WARM: state_next = RUN;
      RUN: begin
        state_next  = RUN;
        if_id_le    = ~stall;
        if_id_reset = squash & ~stall;
        fetch_valid = 1'b1;
        advance     = ~stall;
      end
      default: state_next = RST;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= RST;
    else      state <= state_next;
  end

  // PC/nPC/fetch counter; held whenever not advancing so stalled CTIs are re-evaluated
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      PC          <= RESET_PC;
      nPC         <= RESET_PC + 32'd4;
      fetch_count <= 32'd0;
    end else if (advance) begin
      if (redirect) begin
        PC  <= target;
        nPC <= target + 32'd4;
      end else begin
        PC  <= nPC;
        nPC <= nPC + 32'd4;
      end
      if (!squash) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_sparc_fetch_sequencer.sv
// tb/tb_sparc_fetch_sequencer.sv - scoreboard bench for sparc_fetch_sequencer
module tb_sparc_fetch_sequencer;

  logic        clk;
  logic        clr;
  logic        stall;
  logic        cti_valid;
  logic        cond_true;
  logic        is_ba;
  logic        annul_bit;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic [31:0] PC;
  logic [31:0] nPC;
  logic        if_id_le;
  logic        if_id_reset;
  logic        fetch_valid;
  logic [31:0] fetch_count;

  sparc_fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .clr(clr), .stall(stall), .cti_valid(cti_valid),
    .cond_true(cond_true), .is_ba(is_ba), .annul_bit(annul_bit),
    .branch_target(branch_target), .jump_valid(jump_valid),
    .jump_target(jump_target), .PC(PC), .nPC(nPC), .if_id_le(if_id_le),
    .if_id_reset(if_id_reset), .fetch_valid(fetch_valid),
    .fetch_count(fetch_count)
  );

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        le;
    logic        rst;
    logic        fv;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_id   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL cyc%0d %s actual=%h required=%h", id, nm, act, req);
    end
  endtask

  // Monitor: compares every queued expectation once the cycle's outputs have settled
  always @(negedge clk) begin
    #2;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk32(e.id, "PC", PC, e.pc);
      chk32(e.id, "nPC", nPC, e.npc);
      chk32(e.id, "if_id_le", {31'd0, if_id_le}, {31'd0, e.le});
      chk32(e.id, "if_id_reset", {31'd0, if_id_reset}, {31'd0, e.rst});
      chk32(e.id, "fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
      chk32(e.id, "fetch_count", fetch_count, e.cnt);
    end
  end

  // One cycle: drive clr and ID inputs, push the outputs expected during that cycle
  task automatic cyc(input logic c, input logic st, input logic cv, input logic ct,
                     input logic ba, input logic an, input logic [31:0] bt,
                     input logic jv, input logic [31:0] jt,
                     input logic [31:0] e_pc, input logic [31:0] e_npc,
                     input logic e_le, input logic e_rst, input logic e_fv,
                     input logic [31:0] e_cnt);
    exp_t e;
    @(negedge clk);
    clr = c; stall = st; cti_valid = cv; cond_true = ct; is_ba = ba;
    annul_bit = an; branch_target = bt; jump_valid = jv; jump_target = jt;
    cyc_id++;
    e.id = cyc_id; e.pc = e_pc; e.npc = e_npc; e.le = e_le; e.rst = e_rst;
    e.fv = e_fv; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    clr = 1'b0; stall = 1'b0; cti_valid = 1'b0; cond_true = 1'b0; is_ba = 1'b0;
    annul_bit = 1'b0; branch_target = 32'd0; jump_valid = 1'b0; jump_target = 32'd0;

    //  clr st cv ct ba an  btgt           jv jtgt           PC             nPC            le rst fv cnt
    cyc(0, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,         32'h4,         0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,         32'h4,         0, 1, 0, 0);
    // release: WARM cycle, then sequential fetch
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,         32'h4,         0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,         32'h4,         1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h4,         32'h8,         1, 0, 1, 1);
    // taken branch, a=0
    cyc(1, 0, 1, 1, 0, 0, 32'h40,         0, 32'h0,          32'h8,         32'hC,         1, 0, 1, 2);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h40,        32'h44,        1, 0, 1, 3);
    // untaken branch, a=1: squash
    cyc(1, 0, 1, 0, 0, 1, 32'h200,        0, 32'h0,          32'h44,        32'h48,        1, 1, 1, 4);
    // ba,a: taken and squashed
    cyc(1, 0, 1, 0, 1, 1, 32'h80,         0, 32'h0,          32'h48,        32'h4C,        1, 1, 1, 4);
    // jump with branch fields set, no annul; target low bits masked
    cyc(1, 0, 1, 1, 0, 0, 32'h300,        1, 32'h103,        32'h80,        32'h84,        1, 0, 1, 4);
    // jump wins, branch annul rule (untaken, a=1) still squashes
    cyc(1, 0, 1, 0, 0, 1, 32'h300,        1, 32'h200,        32'h100,       32'h104,       1, 1, 1, 5);
    // stall with ba,a presented for 3 cycles, then released
    cyc(1, 1, 1, 0, 1, 1, 32'h500,        0, 32'h0,          32'h200,       32'h204,       0, 0, 1, 5);
    cyc(1, 1, 1, 0, 1, 1, 32'h500,        0, 32'h0,          32'h200,       32'h204,       0, 0, 1, 5);
    cyc(1, 1, 1, 0, 1, 1, 32'h500,        0, 32'h0,          32'h200,       32'h204,       0, 0, 1, 5);
    cyc(1, 0, 1, 0, 1, 1, 32'h500,        0, 32'h0,          32'h200,       32'h204,       1, 1, 1, 5);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h500,       32'h504,       1, 0, 1, 5);
    // jump near top of address space, then sequential wrap
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFB,  32'h504,       32'h508,       1, 0, 1, 6);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'hFFFF_FFF8, 32'hFFFF_FFFC, 1, 0, 1, 7);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'hFFFF_FFFC, 32'h0,         1, 0, 1, 8);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,         32'h4,         1, 0, 1, 9);
    // branch to 0xFFFFFFFC: nPC wraps to 0
    cyc(1, 0, 1, 1, 0, 0, 32'hFFFF_FFFC,  0, 32'h0,          32'h4,         32'h8,         1, 0, 1, 10);
    // clr pulse with a redirect presented
    cyc(0, 0, 1, 1, 0, 0, 32'h700,        0, 32'h0,          32'h0,         32'h4,         0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 32'h700,        0, 32'h0,          32'h0,         32'h4,         0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,         32'h4,         0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,         32'h4,         1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h4,         32'h8,         1, 0, 1, 1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
